// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle between the execute stage and the
//               iterative multiply/divide unit.
//               master modport (pipeline side):
//                 drives  flush, in_valid, in1, in2, md_op
//                 samples in_ready, out_valid, out, busy
//               slave modport (muldiv_unit side): the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [2:0]       md_op;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output flush, in_valid, in1, in2, md_op,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  flush, in_valid, in1, in2, md_op,
    output in_ready, out_valid, out, busy
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//               multiplier and restoring divider, one bit per CALC cycle,
//               followed by a sign-fix cycle and a one-cycle result pulse.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - muldiv_unit_if.slave: flush, in_valid/in_ready,
//                      in1, in2, md_op, out_valid, out, busy
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_next;

  logic [2:0]         op_q;
  logic               neg_res;
  logic [2*WIDTH-1:0] acc;       // {product high, multiplier / product low}
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;       // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   divisor;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   out_q;
  logic               out_valid_q;

  // --------------------------------------------------------------------------
  // Acceptance and operand decode
  // --------------------------------------------------------------------------
  logic             in_ready_c, accept;
  logic             in1_signed, in2_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag1, mag2;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    in_ready_c = ((state == IDLE) || (state == DONE)) && !bus.flush;
    accept     = bus.in_valid && in_ready_c;

    in1_signed = (bus.md_op == OP_MUL) || (bus.md_op == OP_MULH) ||
                 (bus.md_op == OP_MULHSU) || (bus.md_op == OP_DIV) ||
                 (bus.md_op == OP_REM);
    in2_signed = (bus.md_op == OP_MUL) || (bus.md_op == OP_MULH) ||
                 (bus.md_op == OP_DIV) || (bus.md_op == OP_REM);
    a_neg      = in1_signed && bus.in1[WIDTH-1];
    b_neg      = in2_signed && bus.in2[WIDTH-1];
    mag1       = a_neg ? -bus.in1 : bus.in1;
    mag2       = b_neg ? -bus.in2 : bus.in2;

    // md_op[2]: divide family, md_op[1]: remainder, md_op[0]: unsigned
    div_zero   = bus.md_op[2] && (bus.in2 == '0);
    div_ovf    = bus.md_op[2] && !bus.md_op[0] &&
                 (bus.in1 == MIN_NEG) && (bus.in2 == '1);
    special    = div_zero || div_ovf;
    if (div_zero)
      special_res = bus.md_op[1] ? bus.in1 : '1;
    else
      special_res = bus.md_op[1] ? '0 : bus.in1;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = (state == CALC) || (state == FIX);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = special ? DONE : CALC;
        else        state_next = IDLE;
      end
      CALC:       if (cnt == '0) state_next = FIX;
      FIX:        state_next = DONE;
      default:    state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  // --------------------------------------------------------------------------
  // One iteration of each datapath
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_shift, div_diff;
  logic             div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                (acc[0] ? {1'b0, mcand} : '0);
    // Extra top bit of div_diff is the borrow of the trial subtraction.
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {2'b00, divisor};
    div_ge    = !div_diff[WIDTH+1];
  end

  // --------------------------------------------------------------------------
  // Sign correction and result selection
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_res;

  always_comb begin
    prod = neg_res ? -acc : acc;
    if (op_q[2])
      fix_res = op_q[1] ? (neg_res ? -rem[WIDTH-1:0] : rem[WIDTH-1:0])
                        : (neg_res ? -quo : quo);
    else
      fix_res = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      neg_res     <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      cnt         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_next == DONE);
      if (accept) begin
        op_q    <= bus.md_op;
        // remainder follows the dividend's sign; everything else the xor
        neg_res <= (bus.md_op[2] && bus.md_op[1]) ? a_neg : (a_neg ^ b_neg);
        acc     <= {{WIDTH{1'b0}}, mag2};
        mcand   <= mag1;
        rem     <= '0;
        quo     <= mag1;
        divisor <= mag2;
        cnt     <= CNT_W'(WIDTH - 1);
        if (special) out_q <= special_res;
      end else if (state == CALC) begin
        acc <= {mul_sum, acc[WIDTH-1:1]};
        rem <= div_ge ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
        quo <= {quo[WIDTH-2:0], div_ge};
        cnt <= cnt - CNT_W'(1);
      end else if ((state == FIX) && !bus.flush) begin
        out_q <= fix_res;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. A 32-bit and an 8-bit
//               instance are driven from vector tables; expected results
//               are queued with their due cycle and checked as pulses arrive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010,
                         MULHU = 3'b011, DIV = 3'b100, DIVU = 3'b101,
                         REM = 3'b110, REMU = 3'b111;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic clk, rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t sb32[$];
  exp_t sb8[$];
  vec_t v32[$];
  vec_t v8[$];

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  muldiv_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  // Result monitors: every pulse must match the head of its scoreboard,
  // both in value and in the cycle it was due.
  exp_t e32, e8;
  always @(negedge clk) begin
    if (bus32.out_valid === 1'b1) begin
      if (sb32.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out_valid32: out=%h at cyc %0d, none expected", bus32.out, cyc);
      end else begin
        e32 = sb32.pop_front();
        chk({e32.name, "_val"}, bus32.out, e32.val);
        chk({e32.name, "_cyc"}, 32'(cyc), 32'(e32.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (bus8.out_valid === 1'b1) begin
      if (sb8.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out_valid8: out=%h at cyc %0d, none expected", bus8.out, cyc);
      end else begin
        e8 = sb8.pop_front();
        chk({e8.name, "_val"}, {24'd0, bus8.out}, e8.val);
        chk({e8.name, "_cyc"}, 32'(cyc), 32'(e8.cyc));
      end
    end
  end

  // Present a request and wait for the edge that accepts it. t_acc is the
  // acceptance cycle; the result is due at t_acc + lat.
  task automatic issue(input bit nar, input string nm, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat,
                       input bit hold, input bit want, output int t_acc);
    bit   rdy;
    exp_t e;
    @(negedge clk);
    if (nar) begin
      bus8.md_op = op; bus8.in1 = a[7:0]; bus8.in2 = b[7:0]; bus8.in_valid = 1'b1;
    end else begin
      bus32.md_op = op; bus32.in1 = a; bus32.in2 = b; bus32.in_valid = 1'b1;
    end
    #1;
    rdy = 1'b0;
    for (int k = 0; k < 200; k++) begin
      rdy = nar ? bus8.in_ready : bus32.in_ready;
      if (rdy) break;
      @(negedge clk); #1;
    end
    t_acc = cyc;
    if (!rdy) begin
      tests++; fails++;
      $display("FAIL %s_accept: in_ready never rose, got 0 expected 1", nm);
    end else if (want) begin
      e.name = nm; e.val = exp; e.cyc = cyc + lat;
      if (nar) sb8.push_back(e); else sb32.push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) begin
      if (nar) bus8.in_valid = 1'b0; else bus32.in_valid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (sb32.size() == 0 && sb8.size() == 0) break;
      @(negedge clk); #1;
    end
    while (sb32.size() != 0) begin
      e32 = sb32.pop_front(); tests++; fails++;
      $display("FAIL %s_missing: got no out_valid, expected %h at cyc %0d", e32.name, e32.val, e32.cyc);
    end
    while (sb8.size() != 0) begin
      e8 = sb8.pop_front(); tests++; fails++;
      $display("FAIL %s_missing: got no out_valid, expected %h at cyc %0d", e8.name, e8.val, e8.cyc);
    end
  endtask

  initial begin
    int t1, t2;

    v32.push_back('{"div_neg7_2",    DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34});
    v32.push_back('{"rem_neg7_2",    REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34});
    v32.push_back('{"mulh_min_min",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
    v32.push_back('{"mul_min_min",   MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 34});
    v32.push_back('{"mulhu_ones",    MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    v32.push_back('{"mulhsu_ones",   MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
    v32.push_back('{"divu_by0",      DIVU,   32'd20,        32'd0,         32'hFFFF_FFFF, 1});
    v32.push_back('{"remu_by0",      REMU,   32'd20,        32'd0,         32'h0000_0014, 1});
    v32.push_back('{"div_ovf",       DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    v32.push_back('{"rem_ovf",       REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
    v32.push_back('{"div_by0",       DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1});
    v32.push_back('{"rem_by0",       REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1});
    v32.push_back('{"mul_7_m3",      MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    v32.push_back('{"mulh_7_m3",     MULH,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34});
    v32.push_back('{"mulhu_2p16",    MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 34});
    v32.push_back('{"mulhsu_min_2",  MULHSU, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 34});
    v32.push_back('{"divu_100_7",    DIVU,   32'd100,       32'd7,         32'h0000_000E, 34});
    v32.push_back('{"remu_100_7",    REMU,   32'd100,       32'd7,         32'h0000_0002, 34});
    v32.push_back('{"div_7_m2",      DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34});
    v32.push_back('{"rem_7_m2",      REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34});
    v32.push_back('{"div_m8_m2",     DIV,    32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'h0000_0004, 34});
    v32.push_back('{"remu_max_16",   REMU,   32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 34});

    v8.push_back('{"w8_mulhu_ff",    MULHU,  32'hFF, 32'hFF, 32'hFE, 10});
    v8.push_back('{"w8_div_ovf",     DIV,    32'h80, 32'hFF, 32'h80, 1});
    v8.push_back('{"w8_rem_m7_2",    REM,    32'hF9, 32'h02, 32'hFF, 10});
    v8.push_back('{"w8_mul_15_15",   MUL,    32'h0F, 32'h0F, 32'hE1, 10});
    v8.push_back('{"w8_divu_255_16", DIVU,   32'hFF, 32'h10, 32'h0F, 10});

    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.in1 = '0; bus32.in2 = '0; bus32.md_op = '0;
    bus8.flush  = 1'b0; bus8.in_valid  = 1'b0; bus8.in1  = '0; bus8.in2  = '0; bus8.md_op  = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out32",       bus32.out,       32'h0);
    chk("rst_out_valid32", {31'd0, bus32.out_valid}, 32'd0);
    chk("rst_in_ready32",  {31'd0, bus32.in_ready},  32'd1);
    chk("rst_busy32",      {31'd0, bus32.busy},      32'd0);
    chk("rst_out8",        {24'd0, bus8.out},        32'h0);
    chk("rst_in_ready8",   {31'd0, bus8.in_ready},   32'd1);
    rst = 1'b0;

    foreach (v32[i]) begin
      issue(1'b0, v32[i].name, v32[i].op, v32[i].a, v32[i].b, v32[i].exp, v32[i].lat, 1'b0, 1'b1, t1);
      drain(60);
    end
    foreach (v8[i]) begin
      issue(1'b1, v8[i].name, v8[i].op, v8[i].a, v8[i].b, v8[i].exp, v8[i].lat, 1'b0, 1'b1, t1);
      drain(30);
    end

    // Back-to-back: in_valid stays high, second request taken in DONE
    issue(1'b0, "b2b_first",  MUL,  32'd7,   32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1, 1'b1, t1);
    issue(1'b0, "b2b_second", DIVU, 32'd100, 32'd7,         32'h0000_000E, 34, 1'b0, 1'b1, t2);
    chk("b2b_accept_gap", 32'(t2 - t1), 32'd34);
    drain(80);

    // Flush mid-divide: no result, ready again the cycle after the flush
    issue(1'b0, "flush_divu", DIVU, 32'd100, 32'd7, 32'h0, 34, 1'b0, 1'b0, t1);
    while (cyc < t1 + 5) @(negedge clk);
    #1;
    chk("flush_busy_calc",  {31'd0, bus32.busy},     32'd1);
    chk("flush_ready_calc", {31'd0, bus32.in_ready}, 32'd0);
    while (cyc < t1 + 10) @(negedge clk);
    bus32.flush = 1'b1;
    @(negedge clk);
    bus32.flush = 1'b0;
    #1;
    chk("flush_in_ready", {31'd0, bus32.in_ready},  32'd1);
    chk("flush_busy",     {31'd0, bus32.busy},      32'd0);
    chk("flush_no_valid", {31'd0, bus32.out_valid}, 32'd0);
    repeat (40) @(negedge clk);
    issue(1'b0, "post_flush_divu", DIVU, 32'd100, 32'd7, 32'h0000_000E, 34, 1'b0, 1'b1, t1);
    drain(60);

    // flush together with in_valid: nothing accepted
    @(negedge clk);
    bus32.md_op = DIVU; bus32.in1 = 32'd20; bus32.in2 = 32'd0;
    bus32.in_valid = 1'b1; bus32.flush = 1'b1;
    @(negedge clk);
    bus32.in_valid = 1'b0; bus32.flush = 1'b0;
    #1;
    chk("flush_with_valid_busy",  {31'd0, bus32.busy},      32'd0);
    chk("flush_with_valid_pulse", {31'd0, bus32.out_valid}, 32'd0);
    repeat (5) @(negedge clk);

    // Reset mid-multiply: operation abandoned, out cleared
    issue(1'b0, "rst_mul", MUL, 32'd7, 32'd3, 32'h0, 34, 1'b0, 1'b0, t1);
    while (cyc < t1 + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_out",       bus32.out, 32'h0);
    chk("midrst_out_valid", {31'd0, bus32.out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, bus32.in_ready},  32'd1);
    chk("midrst_busy",      {31'd0, bus32.busy},      32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    drain(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- It accepts one operation at a time over a valid/ready handshake and computes it over multiple cycles with a radix-2 shift-add / restoring-divide datapath.
- It returns the result with a one-cycle out_valid pulse.
- A flush input lets the pipeline kill an in-flight operation on a branch or trap.

Parameters:
- WIDTH, 32: operand and result width in bits; legal range is 4..64.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kills any in-flight operation; takes priority over in_valid.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in1  in  WIDTH  rs1 operand: multiplicand or dividend.
- in2  in  WIDTH  rs2 operand: multiplier or divisor.
- md_op  in  3  operation code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- out_valid  out  1  one-cycle pulse; out holds the result.
- out  out  WIDTH  result; holds its value until the next result is produced.
- busy  out  1  high in the CALC and FIX states.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, out=0, out_valid=0, busy=0, in_ready=1.
  - Reset asserted mid-operation abandons the operation; no out_valid is produced.
- States and transitions:
  - IDLE: wait for a request.
  - CALC: performs exactly WIDTH iterations, tracked by a counter that runs WIDTH-1 down to 0.
  - FIX: sign correction of the result.
  - DONE: out_valid=1 for this single cycle.
- Handshake and acceptance:
  - in_ready = (state==IDLE || state==DONE) && !flush.
  - A request is accepted when in_valid && in_ready. At acceptance, in1, in2 and md_op are latched; inputs are don't-care afterwards.
  - Acceptance in the DONE cycle is legal (back-to-back). The unit leaves DONE straight into the new operation.
- Latency for a request accepted in cycle T:
  - Normal operations: CALC during T+1..T+WIDTH, FIX at T+WIDTH+1, out_valid at T+WIDTH+2 (T+34 for WIDTH=32).
  - Special divide cases: go straight to DONE, out_valid at T+1.
- Special divide cases (decided at acceptance):
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow, in1=100..0 and in2=all ones (DIV/REM only): DIV returns in1; REM returns 0.
- Signed handling:
  - Operands are converted to magnitudes at acceptance:
    - in1 is signed for MUL, MULH, MULHSU, DIV and REM.
    - in2 is signed for MUL, MULH, DIV and REM.
  - FIX negates the result when required:
    - product when the operand signs differ;
    - quotient when the signs differ;
    - remainder when the dividend is negative.
- Multiply result selection:
  - Full 2*WIDTH product accumulator.
  - MUL returns the low WIDTH bits; MULH, MULHSU and MULHU return the high WIDTH bits of the sign-corrected product.
- Divide datapath: restoring; one quotient bit per CALC cycle; remainder register is WIDTH+1 bits.
- Flush:
  - In any state, flush=1 sends the unit to IDLE on the next edge.
  - out_valid is forced to 0 that cycle and out is unchanged.
  - flush together with in_valid: no acceptance.
  - flush in the DONE cycle does not suppress the pulse already being presented.
- Outputs: out and out_valid are registered; no combinational path from in1/in2 to out.

Test Plan (WIDTH=32 unless noted):
1. DIV in1=32'hFFFF_FFF9 (-7), in2=2, accepted at T -> out_valid only at T+34, out=32'hFFFF_FFFD. Then REM on the same operands -> 32'hFFFF_FFFF.
2. MUL, MULH, MULHU and MULHSU:
   - MULH 32'h8000_0000 x 32'h8000_0000 -> 32'h4000_0000.
   - MUL on the same operands -> 32'h0000_0000.
   - MULHU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 32'hFFFF_FFFE.
   - MULHSU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 32'hFFFF_FFFF.
3. Divide by zero:
   - DIVU 20/0 -> 32'hFFFF_FFFF with out_valid at T+1.
   - REMU 20/0 -> 32'h0000_0014 at T+1.
   - Overflow DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000; REM on the same operands -> 0; both at T+1.
4. Flush during DIVU 100/7 at T+10 -> no out_valid ever; in_ready=1 at T+11. A following DIVU 100/7 -> 32'h0000_000E at its own T'+34.
5. Back-to-back: in_valid held high across DONE -> second request accepted in the DONE cycle, with out_valid pulses exactly 34 cycles apart. Reset at T+5 of a MUL -> out=0, out_valid stays 0, in_ready=1 the next cycle.
6. WIDTH=8 build:
   - MULHU 8'hFF x 8'hFF -> 8'hFE at T+10.
   - DIV 8'h80 / 8'hFF -> 8'h80 at T+1.
   - REM 8'hF9 / 8'h02 -> 8'hFF at T+10.
